// File: rtl/nand_dqs_burst_gen.sv
// Framed DQ/DQS burst source: preamble, L strobed beats, postamble, optional gap and repeat.
// Define NAND_BURST_LFSR_EN to build the 16-bit LFSR pattern for mode 2 (otherwise mode 2 = increment).
module nand_dqs_burst_gen #(
    parameter int DQ_W      = 8,
    parameter int MAX_BURST = 16,
    parameter int PRE_CYC   = 1,
    parameter int GAP_W     = 8,
    localparam int LW       = $clog2(MAX_BURST + 1)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic            stop,
    input  logic [LW-1:0]   burst_len,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [1:0]      mode,
    input  logic [DQ_W-1:0] seed,
    input  logic            repeat_mode,
    output logic [DQ_W-1:0] dq_out,
    output logic            dqs_out,
    output logic            oe,
    output logic            busy,
    output logic            done,
    output logic            reject,
    output logic [LW-1:0]   beat_cnt
);

    localparam int PC_W = $clog2(PRE_CYC + 1);

    typedef enum logic [2:0] {IDLE, PRE, BURST, POST, GAP} state_t;

    state_t             state;
    logic [LW-1:0]      cfg_len;
    logic [GAP_W-1:0]   cfg_gap;
    logic [1:0]         cfg_mode;
    logic [DQ_W-1:0]    cfg_seed;
    logic               cfg_rep;
    logic               stop_flag;
    logic [LW-1:0]      k;
    logic [PC_W-1:0]    pre_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               stop_pending;

    assign stop_pending = stop_flag | stop;

`ifdef NAND_BURST_LFSR_EN
    logic [15:0] lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // A zero load would lock the LFSR, so it is forced to 1.
    function automatic logic [15:0] lfsr_load(input logic [DQ_W-1:0] s);
        logic [15:0] v;
        v = 16'({s, s});
        return (v == 16'h0) ? 16'h0001 : v;
    endfunction
`endif

    function automatic logic [DQ_W-1:0] pattern(input logic [LW-1:0] idx);
        logic [31:0] seq;
        int          sh;
        seq = 32'hDEAD_BEEF;
        sh  = (DQ_W == 8) ? 24 - 8 * int'(idx[1:0]) : 16 - 16 * int'(idx[0]);
        case (cfg_mode)
            2'd1:    pattern = cfg_seed;
`ifdef NAND_BURST_LFSR_EN
            2'd2:    pattern = lfsr[DQ_W-1:0];
`endif
            2'd3:    pattern = DQ_W'(seq >> sh);
            default: pattern = cfg_seed + DQ_W'(idx);
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cfg_len   <= '0;
            cfg_gap   <= '0;
            cfg_mode  <= '0;
            cfg_seed  <= '0;
            cfg_rep   <= 1'b0;
            stop_flag <= 1'b0;
            k         <= '0;
            pre_cnt   <= '0;
            gap_cnt   <= '0;
            dq_out    <= '0;
            dqs_out   <= 1'b0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
            beat_cnt  <= '0;
`ifdef NAND_BURST_LFSR_EN
            lfsr      <= 16'h0001;
`endif
        end else begin
            done     <= 1'b0;
            reject   <= 1'b0;
            dq_out   <= '0;
            dqs_out  <= 1'b0;
            beat_cnt <= '0;
            if (state != IDLE && start) reject <= 1'b1;
            if (state != IDLE && stop && cfg_rep) stop_flag <= 1'b1;
            case (state)
                IDLE: begin
                    stop_flag <= 1'b0;
                    if (start) begin
                        if (burst_len == '0) begin
                            reject <= 1'b1;
                        end else begin
                            cfg_len  <= (burst_len > LW'(MAX_BURST)) ? LW'(MAX_BURST) : burst_len;
                            cfg_gap  <= gap_cycles;
                            cfg_mode <= mode;
                            cfg_seed <= seed;
                            cfg_rep  <= repeat_mode;
                            pre_cnt  <= '0;
                            oe       <= 1'b1;
                            busy     <= 1'b1;
                            state    <= PRE;
`ifdef NAND_BURST_LFSR_EN
                            lfsr     <= lfsr_load(seed);
`endif
                        end
                    end
                end
                PRE: begin
                    if (pre_cnt == PC_W'(PRE_CYC - 1)) begin
                        state   <= BURST;
                        k       <= '0;
                        dq_out  <= pattern('0);
                        dqs_out <= 1'b1;
`ifdef NAND_BURST_LFSR_EN
                        lfsr    <= lfsr_step(lfsr);
`endif
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                BURST: begin
                    if (k == cfg_len - 1'b1) begin
                        state <= POST;
                    end else begin
                        // Next beat index is k+1, whose strobe phase equals k[0].
                        k        <= k + 1'b1;
                        dq_out   <= pattern(LW'(k + 1'b1));
                        dqs_out  <= k[0];
                        beat_cnt <= k + 1'b1;
`ifdef NAND_BURST_LFSR_EN
                        lfsr     <= lfsr_step(lfsr);
`endif
                    end
                end
                POST: begin
                    if (cfg_rep && !stop_pending) begin
                        if (cfg_gap != '0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                            oe      <= 1'b0;
                        end else begin
                            state   <= PRE;
                            pre_cnt <= '0;
`ifdef NAND_BURST_LFSR_EN
                            lfsr    <= lfsr_load(cfg_seed);
`endif
                        end
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                        oe    <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    if (stop_pending) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (gap_cnt == cfg_gap - 1'b1) begin
                        state   <= PRE;
                        pre_cnt <= '0;
                        oe      <= 1'b1;
`ifdef NAND_BURST_LFSR_EN
                        lfsr    <= lfsr_load(cfg_seed);
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_dqs_burst_gen.sv
// Directed and randomized bursts checked cycle by cycle against a frame-level reference model.
module tb_nand_dqs_burst_gen;

    localparam int DQ_W      = 8;
    localparam int MAX_BURST = 16;
    localparam int PRE_CYC   = 1;
    localparam int GAP_W     = 8;
    localparam int LW        = 5;
    localparam int RW        = DQ_W + LW + 5;
`ifdef NAND_BURST_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             start, stop, repeat_mode;
    logic [LW-1:0]    burst_len;
    logic [GAP_W-1:0] gap_cycles;
    logic [1:0]       mode;
    logic [DQ_W-1:0]  seed;
    logic [DQ_W-1:0]  dq_out;
    logic             dqs_out, oe, busy, done, reject;
    logic [LW-1:0]    beat_cnt;

    logic [RW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    nand_dqs_burst_gen #(
        .DQ_W(DQ_W), .MAX_BURST(MAX_BURST), .PRE_CYC(PRE_CYC), .GAP_W(GAP_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop),
        .burst_len(burst_len), .gap_cycles(gap_cycles), .mode(mode),
        .seed(seed), .repeat_mode(repeat_mode), .dq_out(dq_out),
        .dqs_out(dqs_out), .oe(oe), .busy(busy), .done(done),
        .reject(reject), .beat_cnt(beat_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [RW-1:0] rec(input logic o, input logic s, input logic [DQ_W-1:0] d,
                                          input logic b, input logic dn, input logic rj,
                                          input logic [LW-1:0] bc);
        return {o, s, d, b, dn, rj, bc};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] e);
        logic [RW-1:0] obs;
        obs = {oe, dqs_out, dq_out, busy, done, reject, beat_cnt};
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h (oe,dqs,dq,busy,done,reject,beat_cnt)", tag, obs, e);
        end
    endtask

    function automatic logic [DQ_W-1:0] beat_value(input int md, input logic [DQ_W-1:0] sd,
                                                   input int kk, input logic [15:0] l);
        logic [7:0] seq [4];
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        if (md == 1) return sd;
        if (md == 3) return seq[kk % 4];
        if (md == 2 && LFSR_ON) return l[DQ_W-1:0];
        return DQ_W'(int'(sd) + kk);
    endfunction

    // Whole transaction as a per-cycle frame list: nb bursts, gaps between them, done, one idle cycle.
    task automatic build(input int len, input int gap, input int md, input logic [DQ_W-1:0] sd, input int nb);
        int L;
        logic [15:0] l;
        L = (len > MAX_BURST) ? MAX_BURST : len;
        for (int b = 0; b < nb; b++) begin
            l = {sd, sd};
            if (l == 16'h0) l = 16'h0001;
            for (int p = 0; p < PRE_CYC; p++) exp_q.push_back(rec(1, 0, 0, 1, 0, 0, 0));
            for (int kk = 0; kk < L; kk++) begin
                exp_q.push_back(rec(1, (kk % 2) == 0, beat_value(md, sd, kk, l), 1, 0, 0, LW'(kk)));
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            exp_q.push_back(rec(1, 0, 0, 1, 0, 0, 0));
            if (b < nb - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(rec(0, 0, 0, 1, 0, 0, 0));
        end
        exp_q.push_back(rec(0, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(rec(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input string name, input int len, input int gap, input int md,
                       input logic [DQ_W-1:0] sd, input bit rep, input int nb, input int rej_at);
        int L, s, n, o_last;
        logic [RW-1:0] e;
        L = (len > MAX_BURST) ? MAX_BURST : len;
        if (!rep) nb = 1;
        exp_q.delete();
        build(len, gap, md, sd, nb);
        o_last = (nb - 1) * (PRE_CYC + L + 1 + gap);
        s = o_last + PRE_CYC - 1 + $urandom_range(0, L - 1);
        if (rej_at >= 0) begin
            e = exp_q[rej_at + 1];
            e[LW] = 1'b1;
            exp_q[rej_at + 1] = e;
        end
        burst_len = LW'(len); gap_cycles = GAP_W'(gap); mode = 2'(md);
        seed = sd; repeat_mode = rep; start = 1'b1;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            stop  = (i == s);
            if (i == rej_at) begin
                start     = 1'b1;
                burst_len = LW'($urandom_range(1, 20));
                seed      = DQ_W'($urandom);
                mode      = 2'($urandom_range(0, 3));
            end
            e = exp_q.pop_front();
            check($sformatf("%s cyc%0d", name, i), e);
        end
        stop = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; stop = 1'b0; repeat_mode = 1'b0;
        burst_len = '0; gap_cycles = '0; mode = '0; seed = '0;
        #12;
        check("reset", rec(0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST_N = 1'b1;

        run("fixed_seq", 4, 0, 3, 8'h00, 0, 1, -1);
        run("incr_clamp", 20, 0, 0, 8'hFE, 0, 1, -1);
        run("repeat_stop", 2, 3, 0, 8'h31, 1, 3, -1);
        run("repeat_nogap", 3, 0, 3, 8'h00, 1, 2, -1);
        run("lfsr", 8, 0, 2, 8'h00, 0, 1, -1);
        run("busy_reject", 6, 0, 1, 8'h5A, 0, 1, 2);

        // start with zero length is refused from IDLE
        burst_len = '0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("len0_reject", rec(0, 0, 0, 0, 0, 1, 0));
        @(posedge CLK); #1;
        check("len0_idle", rec(0, 0, 0, 0, 0, 0, 0));

        // reset asserted in the middle of beat 2
        exp_q.delete();
        build(8, 0, 0, 8'h40, 1);
        burst_len = 5'd8; mode = 2'd0; seed = 8'h40; repeat_mode = 1'b0; start = 1'b1;
        for (int i = 0; i <= PRE_CYC + 2; i++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            check($sformatf("pre_reset cyc%0d", i), exp_q.pop_front());
        end
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset", rec(0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check($sformatf("post_reset_idle%0d", i), rec(0, 0, 0, 0, 0, 0, 0));
        end
        run("after_reset_repeat", 3, 1, 0, 8'h10, 1, 2, -1);

        for (int t = 0; t < 20; t++) begin
            int  len, gap, md, nb, rj, L;
            bit  rep;
            len = $urandom_range(1, 20);
            gap = $urandom_range(0, 4);
            md  = $urandom_range(0, 3);
            rep = 1'($urandom_range(0, 1));
            nb  = $urandom_range(2, 3);
            L   = (len > MAX_BURST) ? MAX_BURST : len;
            rj  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PRE_CYC + L - 1)) : -1;
            run($sformatf("rand%0d", t), len, gap, md, DQ_W'($urandom), rep, nb, rj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nand_dqs_burst_gen.md
# nand_dqs_burst_gen

Synthesizable, parametrised source-synchronous burst generator that drives a NAND-style DQ/DQS pair with framed data bursts: preamble, N data beats with toggling DQS, postamble, and an optional inter-burst gap. It replaces hand-timed DQ/DQS stimulus in the controller bench and serves as an on-chip loopback source for exercising the controller's DQS capture path. It supports several pattern modes, a programmable burst length and gap, and continuous repeat.

## Interface
- DQ_W, 8 — DQ width; legal values 8 or 16.
- MAX_BURST, 16 — maximum beats per burst; at least 2.
- PRE_CYC, 1 — preamble length in cycles; at least 1.
- GAP_W, 8 — width of the gap-cycle count.
- LW = $clog2(MAX_BURST+1) — derived width of the burst-length field.

Ports (clock and reset first):
- CLK  in  1 — the single clock; all flops are rising-edge.
- RST_N  in  1 — asynchronous, active-low reset.
- start  in  1 — burst request; sampled only in IDLE.
- stop  in  1 — request to end repeat mode cleanly.
- burst_len  in  LW — beats per burst; latched on start.
- gap_cycles  in  GAP_W — idle cycles between repeated bursts; latched on start.
- mode  in  2 — pattern select; latched on start.
- seed  in  DQ_W — pattern seed; latched on start.
- repeat  in  1 — continuous bursts; latched on start.
- dq_out  out  DQ_W — data beat.
- dqs_out  out  1 — strobe.
- oe  out  1 — drive enable; high during preamble, burst and postamble.
- busy  out  1 — high whenever the state is not IDLE.
- done  out  1 — one-cycle pulse on return to IDLE.
- reject  out  1 — one-cycle pulse when a start is ignored.
- beat_cnt  out  LW — index of the current beat.

## Operation
- All outputs are registered. Reset value of every output is 0.
- States: IDLE, PRE, BURST, POST, GAP.
- **IDLE**
  - start=1 with burst_len=0 → stay in IDLE, pulse reject.
  - start=1 with burst_len>0 → latch configuration, go to PRE.
  - burst_len>MAX_BURST → clamped to MAX_BURST.
- **Start while busy** → ignored, reject pulses.
- **PRE** → PRE_CYC cycles; oe=1, dqs=0, dq=0. Then go to BURST.
- **BURST** → beats k=0..L-1, one beat per cycle.
  - dq = pattern(k); dqs = ~k[0], so beat 0 has dqs=1; beat_cnt = k.
  - After the last beat, go to POST.
- **POST** → 1 cycle; oe=1, dqs=0, dq=0.
  - If repeat and no stop is pending: go to GAP when gap>0, else directly to PRE.
  - Otherwise go to IDLE and pulse done.
- **GAP** → gap_cycles cycles with oe=0, then go to PRE.
  - A stop arriving during GAP → go to IDLE at the next edge with a done pulse.
- **stop** → sets a sticky flag, cleared in IDLE. The current burst always completes with its full length and postamble. stop outside repeat mode has no effect.
- **Pattern modes:**
  - 0 — increment: seed+k, modulo 2^DQ_W. The value restarts at seed for each burst.
  - 1 — constant seed.
  - 2 — LFSR, see Configuration.
  - 3 — fixed sequence.
    - DQ_W=8: DE, AD, BE, EF, repeating.
    - DQ_W=16: DEAD, BEEF, repeating.
    - Cycles with k modulo 4 or 2 respectively.
- Outside BURST: dq=0 and beat_cnt=0.
- Reset mid-operation → all outputs are 0 immediately (asynchronous), state = IDLE, and the stop flag is cleared.

## Timing
- start high at edge N: busy=oe=1 from N.
- Beat 0 appears after edge N+PRE_CYC.
- Beat L-1 appears after edge N+PRE_CYC+L-1.
- POST follows after the next edge.
- done is high for the cycle following POST; busy=0 in that same cycle.
- Non-repeat burst latency, start to done: PRE_CYC+L+1 cycles.
- Repeat period: PRE_CYC+L+1+gap_cycles cycles.
- A new start is accepted in the same cycle done is high.

## Configuration
- **NAND_BURST_LFSR_EN defined**
  - Mode 2 uses a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  - Each step: shift left; new bit0 = b15^b13^b12^b10.
  - Load value is {seed,seed} truncated to 16 bits; a zero load value is replaced by 16'h0001. The load happens at PRE entry.
  - Beat k outputs lfsr[DQ_W-1:0]; the register steps after each beat.
- **NAND_BURST_LFSR_EN undefined**
  - No LFSR logic is built.
  - Mode 2 behaves exactly as mode 0 (increment).

## Test plan
- **Fixed sequence.** Reset, then start with DQ_W=8, mode=3, burst_len=4 → beats DE/AD/BE/EF with dqs 1/0/1/0. oe is high for 6 cycles. done pulses 6 cycles after start.
- **Increment with clamp.** mode=0, seed=FE, burst_len=20, MAX_BURST=16 → 16 beats FE, FF, 00 … 0D; beat_cnt runs 0..15.
- **Repeat and stop.** repeat=1, gap_cycles=3, L=2 → period 7 cycles with oe low 3 cycles between bursts. stop asserted mid-burst → that burst completes, then IDLE with a single done pulse.
- **Rejects.** start with burst_len=0 → reject pulse, busy stays 0. start during BURST → reject pulse, burst unaffected.
- **LFSR.** With NAND_BURST_LFSR_EN, mode=2, seed=00 → beats are the low bytes of the LFSR sequence from 0001: 01, 02, 04, … Without the macro, identical stimulus yields 00, 01, 02, ….
- **Reset mid-burst.** RST_N low in the middle of beat 2 → all outputs are 0 asynchronously; after release, busy=0 until the next start.
